// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 jump-key receiver.
package ps2_pkg;

  localparam int         DATA_BITS  = 8;
  localparam int         BIT_CNT_W  = $clog2(DATA_BITS);
  localparam logic [7:0] BREAK_CODE = 8'hF0;
  localparam logic [7:0] EXT_CODE   = 8'hE0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_e;

  // Prefix bytes seen since the last ordinary key code.
  typedef struct packed {
    logic brk;
    logic ext;
  } key_flags_t;

  // A frame is good when data plus parity carry an odd number of ones.
  function automatic logic odd_parity(input logic [DATA_BITS-1:0] d, input logic p);
    return ^{d, p};
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizers for the PS/2 clock and data lines plus a
// falling-edge detector on the synchronized clock.
module ps2_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic data,
  output logic fall
);

  logic [1:0] clk_sync;
  logic [1:0] data_sync;
  logic       clk_prev;

  // Flops reset to the idle-high line level so reset release never looks like an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
      clk_prev  <= clk_sync[1];
    end
  end

  assign data = data_sync[1];
  assign fall = clk_prev & ~clk_sync[1];

endmodule

// File: rtl/ps2_jump_receiver.sv
// PS/2 keyboard receiver that decodes make/break of one key into a jump pulse.
// Optional frame timeout enabled by defining PS2_RX_TIMEOUT_EN.
module ps2_jump_receiver
  import ps2_pkg::*;
#(
  parameter logic [7:0] JUMP_CODE      = 8'h29,
  parameter int         TIMEOUT_CYCLES = 200000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] scan_code,
  output logic       code_valid,
  output logic       frame_err,
  output logic       jump,
  output logic       jump_held
);

  ps2_state_e                 state, state_nxt;
  logic [BIT_CNT_W-1:0]       bit_cnt;
  logic [DATA_BITS-1:0]       shift;
  logic                       parity_ok;
  logic                       data;
  logic                       fall;
  logic                       timeout;
  logic                       good;
  logic                       bad;
  key_flags_t                 pend;

  ps2_sync_edge u_sync (
    .clk      (clk),
    .reset    (reset),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .data     (data),
    .fall     (fall)
  );

`ifdef PS2_RX_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt;

  always_ff @(posedge clk) begin
    if (reset || fall || state == IDLE) to_cnt <= '0;
    else                                to_cnt <= to_cnt + TO_W'(1);
  end

  assign timeout = (state != IDLE) && (to_cnt == TO_W'(TIMEOUT_CYCLES));
`else
  // Without the counter a partial frame simply waits for more edges.
  assign timeout = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // A real edge always takes priority over an expiring timeout.
  always_comb begin
    state_nxt = state;
    if (fall) begin
      case (state)
        IDLE:    if (!data) state_nxt = DATA;
        DATA:    if (bit_cnt == BIT_CNT_W'(DATA_BITS - 1)) state_nxt = PARITY;
        PARITY:  state_nxt = STOP;
        STOP:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end else if (timeout) begin
      state_nxt = IDLE;
    end
  end

  always_comb begin
    good = 1'b0;
    bad  = 1'b0;
    if (fall && state == STOP) begin
      good = data & parity_ok;
      bad  = ~(data & parity_ok);
    end else if (timeout) begin
      bad  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt   <= '0;
      shift     <= '0;
      parity_ok <= 1'b0;
    end else if (fall) begin
      case (state)
        IDLE:    bit_cnt <= '0;
        DATA: begin
          shift   <= {data, shift[DATA_BITS-1:1]};
          bit_cnt <= bit_cnt + BIT_CNT_W'(1);
        end
        PARITY:  parity_ok <= odd_parity(shift, data);
        default: ;
      endcase
    end
  end

  // Key tracking: prefixes latch, any other good byte consumes them.
  always_ff @(posedge clk) begin
    if (reset) begin
      scan_code  <= 8'h00;
      code_valid <= 1'b0;
      frame_err  <= 1'b0;
      jump       <= 1'b0;
      jump_held  <= 1'b0;
      pend       <= '0;
    end else begin
      code_valid <= good;
      frame_err  <= bad;
      jump       <= 1'b0;
      if (good) begin
        scan_code <= shift;
        if (shift == BREAK_CODE) begin
          pend.brk <= 1'b1;
        end else if (shift == EXT_CODE) begin
          pend.ext <= 1'b1;
        end else begin
          pend <= '0;
          if (shift == JUMP_CODE && !pend.ext) begin
            if (pend.brk) begin
              jump_held <= 1'b0;
            end else if (!jump_held) begin
              jump      <= 1'b1;
              jump_held <= 1'b1;
            end
          end
        end
      end
    end
  end

endmodule
